// File: rtl/hazard_scoreboard.sv
// D-stage hazard controller: shift scoreboard of in-flight writers, producing
// stall and forward selects, plus a mult/div busy counter.

module hazard_lookup #(
  parameter int STAGES = 3,
  parameter int T_W    = 2,
  parameter int FS_W   = 2
) (
  input  logic [STAGES-1:0][4:0]     addr,
  input  logic [STAGES-1:0][T_W-1:0] t,
  input  logic                       valid,
  input  logic [4:0]                 r_use,
  input  logic [T_W-1:0]             t_use,
  output logic                       hazard,
  output logic [FS_W-1:0]            sel
);
  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    hazard = 1'b0;
    sel    = '0;
    if (valid && r_use != 5'd0) begin
      for (int i = STAGES-1; i >= 0; i--) begin
        if (addr[i] == r_use) begin
          hazard = (t[i] > t_use);
          sel    = (t[i] == '0) ? FS_W'(i+1) : '0;
        end
      end
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int T_W      = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int FS_W     = $clog2(STAGES+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_valid,
  input  logic [4:0]      d_r_new,
  input  logic [4:0]      d_r_use1,
  input  logic [4:0]      d_r_use2,
  input  logic [T_W-1:0]  d_t_new,
  input  logic [T_W-1:0]  d_t_use1,
  input  logic [T_W-1:0]  d_t_use2,
  input  logic            d_md_start,
  input  logic            d_md_is_div,
  input  logic            d_md_use,
  output logic            stall,
  output logic [FS_W-1:0] fwd_sel1,
  output logic [FS_W-1:0] fwd_sel2,
  output logic            md_busy
);
  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MD_W   = $clog2(MD_MAX+1);

  logic [STAGES-1:0][4:0]     addr;
  logic [STAGES-1:0][T_W-1:0] t;
  logic [MD_W-1:0]            md_cnt;
  logic [1:0][4:0]            r_use;
  logic [1:0][T_W-1:0]        t_use;
  logic [1:0]                 hazard;
  logic [1:0][FS_W-1:0]       sel;
  logic                       accept;

  assign r_use = {d_r_use2, d_r_use1};
  assign t_use = {d_t_use2, d_t_use1};

  for (genvar j = 0; j < 2; j++) begin : g_use
    hazard_lookup #(.STAGES(STAGES), .T_W(T_W), .FS_W(FS_W)) u_lookup (
      .addr   (addr),
      .t      (t),
      .valid  (d_valid),
      .r_use  (r_use[j]),
      .t_use  (t_use[j]),
      .hazard (hazard[j]),
      .sel    (sel[j])
    );
  end

  assign md_busy  = (md_cnt != '0);
  assign stall    = d_valid & (|hazard | (d_md_use & md_busy));
  assign accept   = d_valid & ~stall;
  assign fwd_sel1 = sel[0];
  assign fwd_sel2 = sel[1];

  // Downstream never freezes: entries shift every cycle, bubbles enter as empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      t    <= '0;
    end else begin
      for (int i = 1; i < STAGES; i++) begin
        addr[i] <= addr[i-1];
        t[i]    <= (t[i-1] == '0) ? '0 : t[i-1] - 1'b1;
      end
      if (accept && d_r_new != 5'd0) begin
        addr[0] <= d_r_new;
        t[0]    <= (d_t_new == '0) ? '0 : d_t_new - 1'b1;
      end else begin
        addr[0] <= '0;
        t[0]    <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      md_cnt <= '0;
    else if (accept && d_md_start)
      md_cnt <= d_md_is_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard controller for the five-stage MIPS core, sitting beside the D stage. It consumes the per-instruction register/Tuse/Tnew descriptors produced by the D-stage decoder. It tracks every in-flight writer in a shift scoreboard across `STAGES` downstream stages and produces the D-stage stall and D-stage forwarding selects. It also adds a multi-cycle mult/div busy counter that the per-instruction decoder cannot express.

## Interface
Parameters:
- `STAGES`, 3: number of tracked downstream stages; entry 0 = E, 1 = M, 2 = W.
- `T_W`, 2: width of all Tnew/Tuse fields.
- `MULT_LAT`, 5: busy cycles after a mult issues.
- `DIV_LAT`, 10: busy cycles after a div issues.
- `FS_W`, clog2(`STAGES`+1): width of the forward selects.

Ports:
- `clk` in 1: clock. One clock; all state changes on its rising edge.
- `reset` in 1: reset. Asynchronous and active-high.
- `d_valid` in 1: the D stage holds a real instruction.
- `d_r_new`, `d_r_use1`, `d_r_use2` in 5 each: D-stage destination register and two source registers.
- `d_t_new`, `d_t_use1`, `d_t_use2` in `T_W` each: Tnew/Tuse values counted from D.
- `d_md_start` in 1: the D instruction is mult/multu/div/divu.
- `d_md_is_div` in 1: the D instruction is a div variant (valid only with `d_md_start`).
- `d_md_use` in 1: the D instruction needs the mult/div unit or HI/LO (start, mfhi/mflo/mthi/mtlo).
- `stall` out 1: freeze PC and the F/D register and insert a bubble into E.
- `fwd_sel1`, `fwd_sel2` out `FS_W` each: D-operand source. 0 = register file; k = stage entry k-1.
- `md_busy` out 1: the mult/div counter is nonzero.

## Operation
- Each scoreboard entry i holds {`addr`[4:0], `t`[`T_W`-1:0]}. `addr`=0 means empty.
- Hazard lookup for use j, done only when `d_r_use_j` != 0:
  - Scan entries 0..`STAGES`-1 and take the lowest index (youngest) with `addr` == `d_r_use_j`.
  - Raise a hazard when that entry's `t` > `d_t_use_j`.
  - Older matches are ignored.
- `fwd_sel_j` = i+1 when the youngest match has `t`==0; otherwise 0. This includes the case of no match and the case of a match with `t`>0 that does not stall.
- `stall` = `d_valid` & (hazard1 | hazard2 | (`d_md_use` & `md_busy`)).
- Accept = `d_valid` & !`stall`.
- Scoreboard update every cycle:
  - Entry i (i≥1) <= entry i-1 with `t` decremented, saturating at 0.
  - Entry 0 <= {`d_r_new`, sat(`d_t_new`-1)} on accept; otherwise {0,0}.
  - Entries shift even while `stall` is high; the downstream pipeline never freezes.
- A descriptor with `d_r_new`=0 is stored as empty.
- Mult/div counter `md_cnt`, width clog2(max(`MULT_LAT`,`DIV_LAT`)+1):
  - Loads `DIV_LAT` or `MULT_LAT` on accept & `d_md_start`.
  - Otherwise decrements while nonzero.
- A start while busy cannot be accepted, because a start always has `d_md_use` asserted.

## Timing
- Reset values: all entries {0,0}, `md_cnt`=0.
  - `stall`=0 and `fwd_sel`=0 whenever `d_valid`=0.
  - `md_busy`=0.
- Reset asserted mid-operation clears all state immediately. The first accept after reset release sees no hazards.
- `stall` and `fwd_sel*` are combinational from the current entries and D inputs, with zero latency. Register updates take effect at the next rising edge.
- `md_busy` rises the cycle after the start is accepted and stays high for exactly LAT cycles.
- At most one insertion per cycle.
- Simultaneous cases:
  - Both uses hazard: one stall.
  - Register-use hazard and mult/div busy: one stall.
  - Same register written by two entries: the youngest wins.
- `t` never underflows. An entry reaching W with `t`=0 shifts out on the next edge.

## Test plan
- `lw $8` (t_new 3) accepted, then `addu $9,$8,$8` (t_use 1, 1) -> `stall`=1 for exactly one cycle. Next cycle entry 1={8,1}, `stall`=0, `fwd_sel1`=0.
- `addu $5` (t_new 2), then `beq $5,$0` (t_use 0) -> one stall cycle. Next cycle `fwd_sel1`=2 (M, t=0), `fwd_sel2`=0.
- `ori $7` accepted, then `lui $7` accepted, then `jr $7` -> the youngest match (entry 0, lui) decides: one stall, then `fwd_sel1`=2 and not 3.
- `mult` accepted with `MULT_LAT`=5, then `mflo` held in D -> `md_busy` high for 5 cycles, `stall` high for those 5 cycles, and `mflo` is accepted on the 6th. Repeat with `div` and `DIV_LAT`=10 -> 10 stall cycles.
- Uses of `$0` and writers with `d_r_new`=0 -> `stall`=0 and `fwd_sel`=0 throughout.
- Pulse `reset` while `md_cnt`=4 and entry 0={8,2} -> `md_busy`=0 and all entries empty immediately. Dependent `addu $9,$8` right after release -> `stall`=0.
